// File: rtl/fetch_redirect.sv
// Fetch PC generator: single-outstanding instruction bus requests, a valid/ready
// output register toward decode, and squashing of wrong-path work on redirect.
module fetch_redirect #(
  parameter logic [63:0] PC_RESET = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_misalign,
  input  logic        if_ready
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_WAIT, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] pend_q, pend_d;
  logic        stall_q, stall_d;
  logic        out_v_q, out_v_d;
  logic [63:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_mis_q, out_mis_d;
  logic [31:0] buf_instr_q, buf_instr_d;

  logic out_free;
  logic pc_aligned;

  assign out_free   = !out_v_q || if_ready;
  assign pc_aligned = (pc_q[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_REQ;
      pc_q        <= PC_RESET;
      pend_q      <= '0;
      stall_q     <= 1'b0;
      out_v_q     <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      out_mis_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      stall_q     <= stall_d;
      out_v_q     <= out_v_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_mis_q   <= out_mis_d;
    end
    buf_instr_q <= buf_instr_d;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    stall_d     = stall_q;
    out_v_d     = out_v_q && !if_ready;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_mis_d   = out_mis_q;
    buf_instr_d = buf_instr_q;
    if (redirect_valid) begin
      out_v_d = 1'b0;
      stall_d = 1'b0;
      // A request still on the bus must stay stable until its response arrives.
      if (ireq_valid && !iresp_data_ok) begin
        pend_d  = redirect_pc;
        state_d = S_DRAIN;
      end else begin
        pc_d    = redirect_pc;
        state_d = S_REQ;
      end
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (!pc_aligned) begin
            if (out_free) begin
              out_v_d     = 1'b1;
              out_pc_d    = pc_q;
              out_instr_d = '0;
              out_mis_d   = 1'b1;
              stall_d     = 1'b1;
              state_d     = S_WAIT;
            end
          end else if (iresp_data_ok) begin
            pc_d = pc_q + 64'd4;
            if (out_free) begin
              out_v_d     = 1'b1;
              out_pc_d    = pc_q;
              out_instr_d = iresp_data;
              out_mis_d   = 1'b0;
            end else begin
              buf_instr_d = iresp_data;
              state_d     = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // pc already advanced past the buffered word
          if (out_free) begin
            out_v_d     = 1'b1;
            out_pc_d    = pc_q - 64'd4;
            out_instr_d = buf_instr_q;
            out_mis_d   = 1'b0;
            state_d     = S_REQ;
          end
        end
        S_WAIT: begin
          if (out_free && !stall_q) state_d = S_REQ;
        end
        S_DRAIN: begin
          if (iresp_data_ok) begin
            pc_d    = pend_q;
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_comb begin
    ireq_valid  = ((state_q == S_REQ) && pc_aligned) || (state_q == S_DRAIN);
    ireq_addr   = pc_q;
    if_valid    = out_v_q;
    if_pc       = out_pc_q;
    if_instr    = out_instr_q;
    if_misalign = out_mis_q;
  end

endmodule

// File: tb/tb_fetch_redirect.sv
// Bench for fetch_redirect: random bus latency, decode backpressure, redirects and
// resets, checked every cycle against a queue-based fetch model plus literal checks.
module tb_fetch_redirect;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, redirect_valid, ireq_valid, iresp_data_ok, if_valid, if_misalign, if_ready;
  logic [63:0] redirect_pc, ireq_addr, if_pc;
  logic [31:0] iresp_data, if_instr;

  fetch_redirect dut (
    .clk(clk), .resetn(resetn), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .iresp_data_ok(iresp_data_ok),
    .iresp_data(iresp_data), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_misalign(if_misalign), .if_ready(if_ready)
  );

  localparam logic [63:0] PC_RST = 64'h8000_0000;

  typedef struct { logic [63:0] pc; logic [31:0] instr; logic mis; } ent_t;

  int total = 0, bad = 0;

  // Model: entries waiting for decode, next PC to fetch, one request in flight.
  ent_t        q[$];
  bit          m_on = 0, m_infl = 0, m_sq = 0, m_stall = 0;
  logic [63:0] m_pc, m_addr;

  // Bus responder and stimulus knobs
  bit          b_busy = 0;
  int          b_cnt = 0, b_dly = 0, b_nxt = 1, ov_delay = 1;
  int          redir_pct = 0, ready_pct = 100, rst_permil = 0;
  bit          ov_ready_en = 1, ov_ready = 1, do_redir = 0, do_reset = 0;
  logic [63:0] do_target = '0;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B9) ^ a[63:32] ^ 32'h0000_5A5A;
  endfunction

  function automatic int pick_delay();
    return (ov_delay >= 0) ? ov_delay : int'($urandom_range(0, 3));
  endfunction

  function automatic bit m_req();
    return m_infl || (!m_stall && m_pc[1:0] == 2'b00 && q.size() < 2);
  endfunction

  function automatic bit bus_ok_now();
    return ireq_valid && (b_busy ? (b_cnt == b_dly) : (b_nxt == 0));
  endfunction

  function automatic logic [63:0] rand_target();
    logic [63:0] t;
    if ($urandom_range(0, 15) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3) << 2);
    else t = PC_RST + 64'($urandom_range(0, 1023) << 2);
    if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  task automatic set_delay(input int d);
    ov_delay = d;
    b_nxt    = d;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit r;
    r = m_req();
    chk("ireq_valid", 64'(ireq_valid), 64'(r));
    if (r) chk("ireq_addr", ireq_addr, m_infl ? m_addr : m_pc);
    chk("if_valid", 64'(if_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("if_pc", if_pc, q[0].pc);
      chk("if_instr", 64'(if_instr), 64'(q[0].instr));
      chk("if_misalign", 64'(if_misalign), 64'(q[0].mis));
    end
  endtask

  // Called at a falling edge: drive inputs, advance the model, then sample at the next falling edge.
  task automatic cycle();
    bit rst, rd, ok, rdy, req;
    logic [63:0] tg;
    logic [31:0] dat;
    ent_t e;
    rst = do_reset || (int'($urandom_range(0, 999)) < rst_permil);
    if (do_redir) begin rd = 1; tg = do_target; end
    else if (int'($urandom_range(0, 99)) < redir_pct) begin rd = 1; tg = rand_target(); end
    else begin rd = 0; tg = {$urandom, $urandom}; end
    do_redir = 0;
    do_reset = 0;
    rdy = ov_ready_en ? ov_ready : (int'($urandom_range(0, 99)) < ready_pct);
    ok  = 0;
    dat = $urandom;
    if (rst) b_busy = 0;
    else if (ireq_valid) begin
      if (!b_busy) begin b_busy = 1; b_cnt = 0; b_dly = b_nxt; end
      if (b_cnt == b_dly) begin
        ok = 1; b_busy = 0; b_nxt = pick_delay(); dat = word_of(ireq_addr);
      end else b_cnt++;
    end
    resetn = !rst; redirect_valid = rd; redirect_pc = tg;
    iresp_data_ok = ok; iresp_data = dat; if_ready = rdy;

    if (rst) begin
      m_on = 1; m_pc = PC_RST; m_infl = 0; m_sq = 0; m_stall = 0; q.delete();
    end else if (m_on) begin
      req = m_req();
      if (req && !m_infl) begin m_infl = 1; m_sq = 0; m_addr = m_pc; m_pc = m_pc + 64'd4; end
      if (rd) begin
        q.delete();
        m_stall = 0;
        if (m_infl && !ok) m_sq = 1;
        else m_infl = 0;
        m_pc = tg;
      end else begin
        if (q.size() > 0 && rdy) void'(q.pop_front());
        if (m_infl && ok) begin
          if (!m_sq) begin e.pc = m_addr; e.instr = dat; e.mis = 0; q.push_back(e); end
          m_infl = 0; m_sq = 0;
        end else if (!m_infl && !m_stall && m_pc[1:0] != 2'b00 && q.size() == 0) begin
          e.pc = m_pc; e.instr = '0; e.mis = 1; q.push_back(e);
          m_stall = 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (m_on) compare_model();
  endtask

  task automatic wait_ok(input string nm);
    int n = 0;
    while (!bus_ok_now() && n < 20) begin cycle(); n++; end
    if (!bus_ok_now()) begin
      bad++; total++;
      $display("FAIL %s: bus response not reached within 20 cycles", nm);
    end
  endtask

  initial begin
    resetn = 0; redirect_valid = 0; redirect_pc = '0; iresp_data_ok = 0; iresp_data = '0; if_ready = 1;
    set_delay(1);
    do_reset = 1; cycle();
    do_reset = 1; cycle();
    // Reset state and sequential fetch
    chk("rst_req", 64'(ireq_valid), 64'd1);
    chk("rst_addr", ireq_addr, 64'h8000_0000);
    chk("rst_ifv", 64'(if_valid), 64'd0);
    chk("rst_ifpc", if_pc, 64'd0);
    chk("rst_instr", 64'(if_instr), 64'd0);
    chk("rst_mis", 64'(if_misalign), 64'd0);
    cycle();
    chk("t1_addr_stable", ireq_addr, 64'h8000_0000);
    cycle();
    chk("t1_ifpc0", if_pc, 64'h8000_0000);
    chk("t1_instr0", 64'(if_instr), 64'(word_of(64'h8000_0000)));
    chk("t1_addr1", ireq_addr, 64'h8000_0004);
    cycle(); cycle();
    chk("t1_ifpc1", if_pc, 64'h8000_0004);
    chk("t1_addr2", ireq_addr, 64'h8000_0008);
    cycle(); cycle();
    chk("t1_ifpc2", if_pc, 64'h8000_0008);

    // Decode backpressure: one word buffered, then fetch idles
    do_reset = 1; cycle();
    cycle(); cycle();
    chk("t2_ifpc0", if_pc, 64'h8000_0000);
    ov_ready = 0;
    repeat (5) cycle();
    chk("t2_idle", 64'(ireq_valid), 64'd0);
    chk("t2_ifv", 64'(if_valid), 64'd1);
    chk("t2_ifpc_hold", if_pc, 64'h8000_0000);
    ov_ready = 1;
    cycle();
    chk("t2_ifpc1", if_pc, 64'h8000_0004);
    chk("t2_addr2", ireq_addr, 64'h8000_0008);

    // Redirect while 8000_0008 is outstanding, response three cycles later
    set_delay(3);
    do_redir = 1; do_target = 64'h8000_0100; cycle();
    chk("t3_drain_addr", ireq_addr, 64'h8000_0008);
    chk("t3_ifv", 64'(if_valid), 64'd0);
    cycle(); chk("t3_drain_addr1", ireq_addr, 64'h8000_0008);
    cycle(); chk("t3_drain_addr2", ireq_addr, 64'h8000_0008);
    cycle();
    chk("t3_new_addr", ireq_addr, 64'h8000_0100);
    chk("t3_dropped", 64'(if_valid), 64'd0);
    set_delay(1);
    cycle(); cycle();
    chk("t3_ifpc", if_pc, 64'h8000_0100);

    // Redirect together with data_ok, then redirects while draining
    wait_ok("t4_wait");
    do_redir = 1; do_target = 64'h8000_0200; cycle();
    chk("t4_addrA", ireq_addr, 64'h8000_0200);
    chk("t4_ifv", 64'(if_valid), 64'd0);
    set_delay(3);
    do_redir = 1; do_target = 64'h8000_0300; cycle();
    chk("t4_drainA", ireq_addr, 64'h8000_0200);
    do_redir = 1; do_target = 64'h8000_0400; cycle();
    cycle(); cycle();
    chk("t4_latest", ireq_addr, 64'h8000_0400);
    set_delay(1);
    cycle(); cycle();
    chk("t4_ifpc", if_pc, 64'h8000_0400);

    // Misaligned target: fault entry, no bus traffic until the next redirect
    wait_ok("t5_wait");
    do_redir = 1; do_target = 64'h8000_0102; cycle();
    chk("t5_noreq", 64'(ireq_valid), 64'd0);
    cycle();
    chk("t5_ifv", 64'(if_valid), 64'd1);
    chk("t5_mis", 64'(if_misalign), 64'd1);
    chk("t5_ifpc", if_pc, 64'h8000_0102);
    chk("t5_instr", 64'(if_instr), 64'd0);
    repeat (4) cycle();
    chk("t5_idle", 64'(ireq_valid), 64'd0);
    chk("t5_empty", 64'(if_valid), 64'd0);

    // Reset in the middle of a drain
    set_delay(3);
    do_redir = 1; do_target = 64'h8000_0500; cycle();
    chk("t6_addr", ireq_addr, 64'h8000_0500);
    do_redir = 1; do_target = 64'h8000_0600; cycle();
    do_reset = 1; cycle();
    chk("t6_req", 64'(ireq_valid), 64'd1);
    chk("t6_addr_rst", ireq_addr, 64'h8000_0000);
    chk("t6_ifv", 64'(if_valid), 64'd0);
    chk("t6_ifpc", if_pc, 64'd0);
    set_delay(1);
    cycle(); cycle();
    chk("t6_first", if_pc, 64'h8000_0000);
    chk("t6_next_addr", ireq_addr, 64'h8000_0004);

    // Random traffic
    ov_ready_en = 0;
    ov_delay = -1;
    b_nxt = pick_delay();
    for (int ph = 0; ph < 3; ph++) begin
      redir_pct  = (ph == 0) ? 3 : (ph == 1) ? 8 : 15;
      ready_pct  = (ph == 0) ? 80 : (ph == 1) ? 30 : 95;
      rst_permil = 2;
      repeat (2500) cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
